// File: rtl/mem_lsu_ysyx_23060136_if.sv
// Core data-memory bus between the MEM-stage load/store unit and data memory.
// Single-beat request/response: one request, then exactly one response beat.
interface mem_lsu_ysyx_23060136_if;
  // Handshake: a request transfers on a cycle where bus_req_valid && bus_req_ready.
  // Once valid is raised, addr/wen/wdata/wstrb hold stable and valid stays high
  // until that cycle. The response has no ready: bus_resp_valid is a one-cycle
  // beat that the master must take when it is waiting for one.
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );
endinterface

// File: rtl/mem_lsu_ysyx_23060136.sv
// MEM-stage load/store unit: issues single-beat bus accesses, aligns/extends
// load data and emits one registered writeback record per instruction.
module mem_lsu_ysyx_23060136 (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            MEM_i_valid,
  output logic                            MEM_o_ready,
  input  logic [31:0]                     MEM_i_pc,
  input  logic [31:0]                     MEM_i_ALUout,
  input  logic [31:0]                     MEM_i_rs2_data,
  input  logic                            MEM_i_write_mem,
  input  logic                            MEM_i_mem_to_reg,
  input  logic [4:0]                      MEM_i_width,
  input  logic [4:0]                      MEM_i_rd,
  input  logic                            MEM_i_write_gpr,
  mem_lsu_ysyx_23060136_if.master         bus,
  output logic                            MEM_o_valid,
  output logic [31:0]                     MEM_o_pc,
  output logic [4:0]                      MEM_o_rd,
  output logic                            MEM_o_write_gpr,
  output logic [31:0]                     MEM_o_wb_data,
  output logic                            MEM_o_misalign,
  output logic [1:0]                      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [31:0] lat_pc;
  logic [31:0] lat_addr;
  logic [4:0]  lat_rd;
  logic        lat_write_gpr;
  logic        lat_load;
  logic [4:0]  lat_width;

  // Width is one-hot {byte, half, word, byte_u, half_u}.
  logic w_byte, w_half, w_word, w_byte_u, w_half_u;
  assign w_byte   = MEM_i_width[4];
  assign w_half   = MEM_i_width[3];
  assign w_word   = MEM_i_width[2];
  assign w_byte_u = MEM_i_width[1];
  assign w_half_u = MEM_i_width[0];

  logic is_mem;
  logic misalign;
  assign is_mem   = MEM_i_write_mem | MEM_i_mem_to_reg;
  assign misalign = is_mem &
                    ((((w_half | w_half_u) & MEM_i_ALUout[0])) |
                     (w_word & (MEM_i_ALUout[1:0] != 2'b00)));

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = MEM_i_rs2_data;
    if (w_byte | w_byte_u) begin
      st_strb  = 4'b0001 << MEM_i_ALUout[1:0];
      st_wdata = {4{MEM_i_rs2_data[7:0]}};
    end else if (w_half | w_half_u) begin
      st_strb  = MEM_i_ALUout[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{MEM_i_rs2_data[15:0]}};
    end else if (w_word) begin
      st_strb  = 4'b1111;
      st_wdata = MEM_i_rs2_data;
    end
  end

  // Load lanes are selected by the low address bits latched at acceptance.
  logic [31:0] byte_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  assign byte_shift = bus.bus_resp_rdata >> {lat_addr[1:0], 3'b000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = lat_addr[1] ? bus.bus_resp_rdata[31:16] : bus.bus_resp_rdata[15:0];

  always_comb begin
    ld_data = bus.bus_resp_rdata;
    if (lat_width[4])      ld_data = {{24{ld_byte[7]}}, ld_byte};
    else if (lat_width[3]) ld_data = {{16{ld_half[15]}}, ld_half};
    else if (lat_width[1]) ld_data = {24'h0, ld_byte};
    else if (lat_width[0]) ld_data = {16'h0, ld_half};
  end

  assign MEM_o_ready = (state == IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lat_pc            <= '0;
      lat_addr          <= '0;
      lat_rd            <= '0;
      lat_write_gpr     <= 1'b0;
      lat_load          <= 1'b0;
      lat_width         <= '0;
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= '0;
      bus.bus_req_wen   <= 1'b0;
      bus.bus_req_wdata <= '0;
      bus.bus_req_wstrb <= '0;
      MEM_o_valid       <= 1'b0;
      MEM_o_pc          <= '0;
      MEM_o_rd          <= '0;
      MEM_o_write_gpr   <= 1'b0;
      MEM_o_wb_data     <= '0;
      MEM_o_misalign    <= 1'b0;
    end else begin
      MEM_o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (MEM_i_valid) begin
            if (!is_mem || misalign) begin
              MEM_o_valid     <= 1'b1;
              MEM_o_pc        <= MEM_i_pc;
              MEM_o_rd        <= MEM_i_rd;
              MEM_o_write_gpr <= MEM_i_write_gpr & ~misalign;
              MEM_o_wb_data   <= MEM_i_ALUout;
              MEM_o_misalign  <= misalign;
            end else begin
              lat_pc            <= MEM_i_pc;
              lat_addr          <= MEM_i_ALUout;
              lat_rd            <= MEM_i_rd;
              lat_write_gpr     <= MEM_i_write_gpr;
              lat_load          <= MEM_i_mem_to_reg;
              lat_width         <= MEM_i_width;
              bus.bus_req_valid <= 1'b1;
              bus.bus_req_addr  <= {MEM_i_ALUout[31:2], 2'b00};
              bus.bus_req_wen   <= MEM_i_write_mem;
              bus.bus_req_wdata <= st_wdata;
              bus.bus_req_wstrb <= MEM_i_write_mem ? st_strb : 4'b0000;
              state             <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            bus.bus_req_valid <= 1'b0;
            state             <= RESP;
          end
        end
        RESP: begin
          if (bus.bus_resp_valid) begin
            MEM_o_valid     <= 1'b1;
            MEM_o_pc        <= lat_pc;
            MEM_o_rd        <= lat_rd;
            MEM_o_write_gpr <= lat_write_gpr;
            MEM_o_wb_data   <= lat_load ? ld_data : lat_addr;
            MEM_o_misalign  <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_ysyx_23060136.sv
// Directed bench for the MEM-stage LSU; writeback records are scoreboarded
// through an expected queue and bus requests are checked cycle by cycle.
module tb_mem_lsu_ysyx_23060136;

  logic        clk;
  logic        rst_n;
  logic        MEM_i_valid;
  logic        MEM_o_ready;
  logic [31:0] MEM_i_pc;
  logic [31:0] MEM_i_ALUout;
  logic [31:0] MEM_i_rs2_data;
  logic        MEM_i_write_mem;
  logic        MEM_i_mem_to_reg;
  logic [4:0]  MEM_i_width;
  logic [4:0]  MEM_i_rd;
  logic        MEM_i_write_gpr;
  logic        MEM_o_valid;
  logic [31:0] MEM_o_pc;
  logic [4:0]  MEM_o_rd;
  logic        MEM_o_write_gpr;
  logic [31:0] MEM_o_wb_data;
  logic        MEM_o_misalign;
  logic [1:0]  dbg_state;

  mem_lsu_ysyx_23060136_if bus_if();

  mem_lsu_ysyx_23060136 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MEM_i_valid      (MEM_i_valid),
    .MEM_o_ready      (MEM_o_ready),
    .MEM_i_pc         (MEM_i_pc),
    .MEM_i_ALUout     (MEM_i_ALUout),
    .MEM_i_rs2_data   (MEM_i_rs2_data),
    .MEM_i_write_mem  (MEM_i_write_mem),
    .MEM_i_mem_to_reg (MEM_i_mem_to_reg),
    .MEM_i_width      (MEM_i_width),
    .MEM_i_rd         (MEM_i_rd),
    .MEM_i_write_gpr  (MEM_i_write_gpr),
    .bus              (bus_if.master),
    .MEM_o_valid      (MEM_o_valid),
    .MEM_o_pc         (MEM_o_pc),
    .MEM_o_rd         (MEM_o_rd),
    .MEM_o_write_gpr  (MEM_o_write_gpr),
    .MEM_o_wb_data    (MEM_o_wb_data),
    .MEM_o_misalign   (MEM_o_misalign),
    .dbg_state        (dbg_state)
  );

  localparam logic [4:0] W_B  = 5'b10000;
  localparam logic [4:0] W_H  = 5'b01000;
  localparam logic [4:0] W_W  = 5'b00100;
  localparam logic [4:0] W_BU = 5'b00010;
  localparam logic [4:0] W_HU = 5'b00001;

  // Record layout: {pc, rd, write_gpr, wb_data, misalign}
  logic [70:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every writeback beat must match the oldest expected record
  always @(negedge clk) begin
    if (MEM_o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {1'b0, MEM_o_pc, MEM_o_rd, MEM_o_write_gpr, MEM_o_wb_data, MEM_o_misalign}, 72'h0);
      end else begin
        chk("wb_record", {1'b0, MEM_o_pc, MEM_o_rd, MEM_o_write_gpr, MEM_o_wb_data, MEM_o_misalign},
            {1'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic wmem, input logic m2r, input logic [4:0] width,
                           input logic [4:0] rd, input logic wgpr);
    MEM_i_valid      = 1'b1;
    MEM_i_pc         = pc;
    MEM_i_ALUout     = alu;
    MEM_i_rs2_data   = rs2;
    MEM_i_write_mem  = wmem;
    MEM_i_mem_to_reg = m2r;
    MEM_i_width      = width;
    MEM_i_rd         = rd;
    MEM_i_write_gpr  = wgpr;
  endtask

  task automatic chk_req(input string tag, input logic [31:0] e_addr, input logic e_wen,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata);
    chk({tag, "_req_valid"}, 72'(bus_if.bus_req_valid), 72'd1);
    chk({tag, "_req_addr"}, 72'(bus_if.bus_req_addr), 72'(e_addr));
    chk({tag, "_req_wen"}, 72'(bus_if.bus_req_wen), 72'(e_wen));
    chk({tag, "_req_wstrb"}, 72'(bus_if.bus_req_wstrb), 72'(e_strb));
    if (e_wen) chk({tag, "_req_wdata"}, 72'(bus_if.bus_req_wdata), 72'(e_wdata));
    chk({tag, "_ready_low"}, 72'(MEM_o_ready), 72'd0);
  endtask

  // Full memory op: accept at T, request from T+1 held for rdly extra cycles,
  // response after pdly idle cycles, writeback one cycle after the beat.
  task automatic mem_op(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic wmem, input logic [4:0] width,
                        input logic [4:0] rd, input logic wgpr, input int rdly, input int pdly,
                        input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_wb);
    step();
    drive_rec(pc, alu, rs2, wmem, ~wmem, width, rd, wgpr);
    exp_q.push_back({pc, rd, wgpr, e_wb, 1'b0});
    step();
    MEM_i_valid = 1'b0;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      chk_req(tag, e_addr, wmem, e_strb, e_wdata);
      step();
    end
    bus_if.bus_req_ready = 1'b1;
    @(negedge clk);
    chk_req(tag, e_addr, wmem, e_strb, e_wdata);
    step();
    bus_if.bus_req_ready = 1'b0;
    for (int k = 0; k < pdly; k++) begin
      @(negedge clk);
      chk({tag, "_wait_ready_low"}, 72'(MEM_o_ready), 72'd0);
      chk({tag, "_wait_req_low"}, 72'(bus_if.bus_req_valid), 72'd0);
      step();
    end
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_rdata = rdata;
    @(negedge clk);
    chk({tag, "_resp_ready_low"}, 72'(MEM_o_ready), 72'd0);
    step();
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = $urandom();
    @(negedge clk);
    chk({tag, "_wb_valid"}, 72'(MEM_o_valid), 72'd1);
    chk({tag, "_ready_back"}, 72'(MEM_o_ready), 72'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_rec(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'h0, 5'h0, 1'b0);
    MEM_i_valid = 1'b0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 72'(bus_if.bus_req_valid), 72'd0);
    chk("rst_o_record", {1'b0, MEM_o_valid, MEM_o_pc, MEM_o_rd, MEM_o_write_gpr, MEM_o_wb_data, MEM_o_misalign}, 72'h0);
    chk("rst_req_fields", {bus_if.bus_req_addr, bus_if.bus_req_wen, bus_if.bus_req_wdata, bus_if.bus_req_wstrb}, 72'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 72'(MEM_o_ready), 72'd1);
    chk("post_rst_state", 72'(dbg_state), 72'd0);

    // non-memory stream, one record per cycle
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = 32'h11 * (i + 1);
      step();
      drive_rec(32'h100 + 4 * i, v, $urandom(), 1'b0, 1'b0, W_W, 5'(i + 1), 1'b1);
      exp_q.push_back({32'h100 + 32'(4 * i), 5'(i + 1), 1'b1, v, 1'b0});
      @(negedge clk);
      chk("stream_ready", 72'(MEM_o_ready), 72'd1);
      if (i > 0) chk("stream_valid", 72'(MEM_o_valid), 72'd1);
    end
    step();
    MEM_i_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 72'(MEM_o_valid), 72'd1);
    @(negedge clk);
    chk("stream_valid_drop", 72'(MEM_o_valid), 72'd0);

    // lb / lbu at 0x1003
    mem_op("lb", 32'h200, 32'h1003, 32'h0, 1'b0, W_B, 5'd5, 1'b1, 0, 0,
           32'h80FF_1234, 32'h1000, 4'b0000, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", 32'h204, 32'h1003, 32'h0, 1'b0, W_BU, 5'd6, 1'b1, 0, 0,
           32'h80FF_1234, 32'h1000, 4'b0000, 32'h0, 32'h0000_0080);

    // sh with two ready stall cycles
    mem_op("sh", 32'h208, 32'h2002, 32'hABCD_5678, 1'b1, W_H, 5'd0, 1'b0, 2, 0,
           32'h0, 32'h2000, 4'b1100, 32'h5678_5678, 32'h2002);

    // misaligned lw: no bus request, record next cycle
    step();
    drive_rec(32'h20C, 32'h3001, 32'h0, 1'b0, 1'b1, W_W, 5'd7, 1'b1);
    exp_q.push_back({32'h20C, 5'd7, 1'b0, 32'h3001, 1'b1});
    step();
    MEM_i_valid = 1'b0;
    @(negedge clk);
    chk("lw_mis_no_req", 72'(bus_if.bus_req_valid), 72'd0);
    chk("lw_mis_valid", 72'(MEM_o_valid), 72'd1);
    chk("lw_mis_ready", 72'(MEM_o_ready), 72'd1);

    // lh with response delayed 4 cycles
    mem_op("lh", 32'h210, 32'h4002, 32'h0, 1'b0, W_H, 5'd8, 1'b1, 0, 4,
           32'h8001_0000, 32'h4000, 4'b0000, 32'h0, 32'hFFFF_8001);

    // remaining lanes and widths
    mem_op("sb", 32'h214, 32'h5001, 32'h1234_56AB, 1'b1, W_B, 5'd0, 1'b0, 1, 1,
           32'h0, 32'h5000, 4'b0010, 32'hABAB_ABAB, 32'h5001);
    mem_op("sw", 32'h218, 32'h6000, 32'hDEAD_BEEF, 1'b1, W_W, 5'd0, 1'b0, 0, 0,
           32'h0, 32'h6000, 4'b1111, 32'hDEAD_BEEF, 32'h6000);
    mem_op("lhu", 32'h21C, 32'h7000, 32'h0, 1'b0, W_HU, 5'd9, 1'b1, 0, 1,
           32'h1234_8765, 32'h7000, 4'b0000, 32'h0, 32'h0000_8765);
    mem_op("lw", 32'h220, 32'h7004, 32'h0, 1'b0, W_W, 5'd10, 1'b1, 0, 0,
           32'hCAFE_F00D, 32'h7004, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // reset while waiting in RESP, then a stray response
    step();
    drive_rec(32'h300, 32'h8000, 32'h0, 1'b0, 1'b1, W_W, 5'd11, 1'b1);
    step();
    MEM_i_valid = 1'b0;
    bus_if.bus_req_ready = 1'b1;
    step();
    bus_if.bus_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_resp", 72'(dbg_state), 72'd2);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_record", {1'b0, MEM_o_valid, MEM_o_pc, MEM_o_rd, MEM_o_write_gpr, MEM_o_wb_data, MEM_o_misalign}, 72'h0);
    chk("rst_mid_req", {bus_if.bus_req_valid, bus_if.bus_req_addr, bus_if.bus_req_wen, bus_if.bus_req_wstrb}, 72'h0);
    chk("rst_mid_ready", 72'(MEM_o_ready), 72'd1);
    step();
    rst_n = 1'b1;
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("stray_state", 72'(dbg_state), 72'd0);
    step();
    bus_if.bus_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_no_wb", 72'(MEM_o_valid), 72'd0);
    chk("stray_ready", 72'(MEM_o_ready), 72'd1);
    repeat (2) @(negedge clk);
    chk("queue_drained", 72'(exp_q.size()), 72'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
